// File: rtl/prbs_pkg.sv
// Shared definitions for the LFSR m-sequence generator and checker.
package prbs_pkg;

  localparam logic [7:0]  TAPS8  = 8'h8E;
  localparam logic [15:0] TAPS16 = 16'h95CC;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} chk_state_t;

  // One LFSR shift: left shift, XOR of tapped bits enters bit 0.
  // Operands are zero-extended to 16 bits; bits at and above width are masked off.
  function automatic logic [15:0] lfsr_next(input logic [15:0] x,
                                            input logic [15:0] taps,
                                            input int unsigned width);
    logic [15:0] r;
    logic [16:0] mask;
    mask = (17'd1 << width) - 17'd1;
    r    = {x[14:0], ^(x & taps)};
    return r & mask[15:0];
  endfunction

endpackage

// File: rtl/prbs_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W:0] sum;

  assign sum = {1'b0, cnt} + (CNT_W + 1)'(inc);

  // Count by inc when enabled; clear and reset win, overflow pins at all-ones.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/prbs_seq_checker.sv
// Receive-side checker for LFSR m-sequence state words: self-synchronises on
// a run of consistent words, then flywheels and counts word errors.
// Optional feature macro: PRBS_SEQ_CHECKER_BITERR_EN adds biterr_cnt.
module prbs_seq_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(TAPS8),
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_CNT = 8,
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] word_cnt,
`ifdef PRBS_SEQ_CHECKER_BITERR_EN
  output logic [CNT_W-1:0] biterr_cnt,
`endif
  output logic [CNT_W-1:0] err_cnt
);

  localparam int PC_W = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    logic [15:0] r;
    r = lfsr_next(16'(x), 16'(TAPS), WIDTH);
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] x);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + PC_W'(x[i]);
    return c;
  endfunction

  chk_state_t       state;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] expected;
  logic             seed_vld;
  logic [7:0]       run;
  logic [7:0]       miss;

  logic       seed_match;
  logic       mismatch;
  logic       count_en;
  logic [7:0] run_inc;
  logic [7:0] miss_inc;

  assign seed_match = seed_vld && (din == nxt(seed));
  assign mismatch   = (din != expected);
  assign run_inc    = run + 8'd1;
  assign miss_inc   = miss + 8'd1;
  assign count_en   = din_valid && (state == LOCKED) && !clear;
  assign locked     = (state == LOCKED);

  // Hunt for a consistent run of words, then flywheel and track misses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      seed      <= '0;
      seed_vld  <= 1'b0;
      run       <= '0;
      miss      <= '0;
      expected  <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (din_valid) begin
        if (state == HUNT) begin
          seed     <= din;
          seed_vld <= (din != '0);
          if (seed_match) begin
            run <= run_inc;
            if (run_inc == 8'(LOCK_CNT)) begin
              state    <= LOCKED;
              expected <= nxt(din);
              miss     <= '0;
            end
          end else begin
            run <= '0;
          end
        end else begin
          expected <= nxt(expected);
          if (mismatch) begin
            err_pulse <= 1'b1;
            miss      <= miss_inc;
            if (miss_inc == 8'(LOSS_CNT)) begin
              state    <= HUNT;
              seed_vld <= 1'b0;
              run      <= '0;
            end
          end else begin
            miss <= '0;
          end
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_word_cnt (
    .clk(clk), .reset(reset), .clear(clear),
    .en(count_en), .inc(1'b1), .cnt(word_cnt)
  );

  sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_err_cnt (
    .clk(clk), .reset(reset), .clear(clear),
    .en(count_en && mismatch), .inc(1'b1), .cnt(err_cnt)
  );

`ifdef PRBS_SEQ_CHECKER_BITERR_EN
  sat_counter #(.CNT_W(CNT_W), .INC_W(PC_W)) u_biterr_cnt (
    .clk(clk), .reset(reset), .clear(clear),
    .en(count_en), .inc(popcount(din ^ expected)), .cnt(biterr_cnt)
  );
`endif

endmodule
